uart_rx: RTL and testbench

- 8N1 asynchronous serial receiver for the UART2 RX pin: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Runs from the 50 MHz board clock at 9600 baud by default and samples each bit at mid-bit.
- Presents the last correctly framed byte on data_out and holds it until the next good frame.
- Sits directly behind the board RX pin. SW0 acts as reset.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx.sv | 116 +++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Frame format is fixed at 8N1; only the clock and bit rate are tunable.
package uart_pkg;

    localparam int unsigned DEFAULT_CLK_FREQ_HZ = 50_000_000;
    localparam int unsigned DEFAULT_BAUD        = 9_600;
    localparam int unsigned DATA_BITS           = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Integer division truncates; the residual error is far below receiver tolerance.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq_hz,
                                                 input int unsigned baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin.
// Resets to the idle-high line level so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_async,
    output logic rx_s
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx_async;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, holds the last correctly framed byte.
// Framing errors leave data_out untouched and wait for the line to return high.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
    parameter int unsigned BAUD        = DEFAULT_BAUD
) (
    input  logic       clk_50MHz,
    input  logic       SW0,
    input  logic       UART2_RX,
    output logic [7:0] data_out
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [7:0]           data_d;

    uart_rx_sync u_sync (
        .clk      (clk_50MHz),
        .rst      (SW0),
        .rx_async (UART2_RX),
        .rx_s     (rx_s)
    );

    always_ff @(posedge clk_50MHz or posedge SW0) begin
        if (SW0) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            data_out <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            data_out <= data_d;
        end
    end

    // Every state transition also clears the clock counter, so each phase times from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_out;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shreg_q;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_HIGH;
                    end
                end
            end

            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// compared every cycle against a frame-level model of when data_out must change.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned TB_CLK_HZ = 960_000;
    localparam int unsigned TB_BAUD   = 9_600;
    localparam int unsigned CPB       = TB_CLK_HZ / TB_BAUD;
    // Stop bit sampled 9.5 bit periods after the start edge, plus the synchronizer delay.
    localparam int unsigned UPD_LAT   = (19 * CPB) / 2 + 2;
    localparam int unsigned CYCLE_LIMIT = 80_000;

    logic       clk_50MHz = 1'b0;
    logic       SW0       = 1'b1;
    logic       UART2_RX  = 1'b1;
    logic [7:0] data_out;

    uart_rx #(.CLK_FREQ_HZ(TB_CLK_HZ), .BAUD(TB_BAUD)) dut (
        .clk_50MHz (clk_50MHz),
        .SW0       (SW0),
        .UART2_RX  (UART2_RX),
        .data_out  (data_out)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    int unsigned cyc = 0;
    always @(posedge clk_50MHz) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: queue of (cycle, value) updates scheduled when a good frame starts.
    logic [7:0]  exp_q = 8'h00;
    int unsigned ev_cyc[$];
    logic [7:0]  ev_val[$];

    always @(negedge clk_50MHz) begin
        if (SW0) begin
            exp_q = 8'h00;
            ev_cyc.delete();
            ev_val.delete();
        end else begin
            while (ev_cyc.size() > 0 && ev_cyc[0] <= cyc) begin
                exp_q = ev_val[0];
                void'(ev_cyc.pop_front());
                void'(ev_val.pop_front());
            end
        end
        check8("data_out", data_out, exp_q);
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk_50MHz);
        #1;
    endtask

    task automatic check_state(input string name, input rx_state_t exp);
        check8(name, 8'(dut.state_q), 8'(exp));
    endtask

    // Called aligned 1 time unit after a clock edge; returns with the same alignment.
    task automatic send_frame(input logic [7:0] b, input int unsigned bp,
                              input bit stop_ok, input int abort_bit);
        UART2_RX = 1'b0;
        if (stop_ok) begin
            ev_cyc.push_back(cyc + 1 + UPD_LAT);
            ev_val.push_back(b);
        end
        tick(bp);
        for (int n = 0; n < 8; n++) begin
            UART2_RX = b[n];
            if (n == abort_bit) begin
                tick(bp / 2);
                SW0 = 1'b1;
                #1;
                check8("reset_async", data_out, 8'h00);
                tick(20);
                UART2_RX = 1'b1;
                SW0 = 1'b0;
                return;
            end
            tick(bp);
        end
        UART2_RX = stop_ok;
        tick(bp);
    endtask

    initial begin
        #(CYCLE_LIMIT * 10);
        $display("FAIL watchdog: simulation exceeded %0d cycles", CYCLE_LIMIT);
        $fatal(1);
    end

    initial begin
        logic [7:0]  rb;
        int unsigned rbp;
        bit          rok;
        int unsigned sel;

        @(posedge clk_50MHz);
        #1;
        tick(100);
        check8("reset_data", data_out, 8'h00);
        check_state("reset_state", IDLE);
        SW0 = 1'b0;
        tick(200);
        check8("idle_hold", data_out, 8'h00);

        send_frame(8'h4A, CPB, 1'b1, -1);
        tick(200);
        check8("frame_4A", data_out, 8'h4A);

        UART2_RX = 1'b0;
        tick(20);
        UART2_RX = 1'b1;
        tick(80);
        check_state("false_start_idle", IDLE);
        check8("false_start_data", data_out, 8'h4A);

        send_frame(8'hA5, CPB, 1'b0, -1);
        check_state("framing_wait_high", WAIT_HIGH);
        tick(300);
        UART2_RX = 1'b1;
        tick(10);
        check_state("framing_idle", IDLE);
        check8("framing_keep", data_out, 8'h4A);
        send_frame(8'h3C, CPB, 1'b1, -1);
        tick(50);
        check8("frame_3C", data_out, 8'h3C);

        send_frame(8'h55, CPB + 2, 1'b1, -1);
        send_frame(8'hFF, CPB - 2, 1'b1, -1);
        tick(50);
        check8("b2b_FF", data_out, 8'hFF);
        send_frame(8'h55, CPB - 2, 1'b1, -1);
        send_frame(8'hFF, CPB + 2, 1'b1, -1);
        tick(50);
        check8("b2b_FF_slow", data_out, 8'hFF);

        send_frame(8'h81, CPB, 1'b1, 4);
        check8("abort_data", data_out, 8'h00);
        tick(50);
        check8("abort_hold", data_out, 8'h00);
        send_frame(8'h81, CPB, 1'b1, -1);
        tick(50);
        check8("frame_81", data_out, 8'h81);

        for (int i = 0; i < 24; i++) begin
            rb  = 8'($urandom_range(0, 255));
            sel = $urandom_range(0, 2);
            rbp = (sel == 0) ? CPB - 2 : ((sel == 1) ? CPB : CPB + 2);
            rok = ($urandom_range(0, 5) != 0);
            send_frame(rb, rbp, rok, -1);
            if (!rok) begin
                tick($urandom_range(0, 150));
                UART2_RX = 1'b1;
                tick($urandom_range(5, 40));
            end else begin
                sel = $urandom_range(0, 2);
                if (sel == 1) begin
                    tick($urandom_range(1, 100));
                end else if (sel == 2) begin
                    UART2_RX = 1'b0;
                    tick($urandom_range(1, 30));
                    UART2_RX = 1'b1;
                    tick($urandom_range(60, 120));
                end
            end
        end

        tick(UPD_LAT + 100);
        check_state("final_idle", IDLE);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
